multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning 1 = honour mem_ready and 0 = treat mem_ready as constant 1.
REQ-002 SHALL have parameter ILLEGAL_HALT, default 1, meaning 1 = an illegal opcode halts until reset and 0 = the controller skips back to FETCH.
REQ-003 SHALL have parameter STATE_W, default 4, giving the state register width.
REQ-004 clk  input  1  single clock, all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 op  input  7  opcode field of the instruction register.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 PCUpdate, IRWrite, RegWrite, MemWrite, Branch  output  1 each  write strobes.
REQ-009 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc  output  2 each  datapath selects.
REQ-011 halted  output  1  sticky illegal-opcode flag.
REQ-012 state_dbg  output  STATE_W  current state, for debug only.

Function
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL and HALT.
REQ-014 Transitions SHALL be: FETCH->DECODE on mem_ready; DECODE->MEMADR for op 0000011 or 0100011, ->EXECR for 0110011, ->EXECI for 0010011, ->BEQ for 1100011, ->JAL for 1101111, and ->HALT (ILLEGAL_HALT=1) or ->FETCH (ILLEGAL_HALT=0) for any other op.
REQ-015 Further transitions SHALL be: MEMADR->MEMREAD for lw, else ->MEMWRITE; MEMREAD->MEMWB on mem_ready; MEMWRITE->FETCH on mem_ready; EXECR, EXECI and JAL ->ALUWB; MEMWB, ALUWB and BEQ ->FETCH; HALT->HALT.
REQ-016 Outputs SHALL be a Moore function of state only (except ImmSrc and the strobes gated per REQ-018), with every output not listed for a state driven to 0.
REQ-017 Per-state outputs SHALL be:
- FETCH: ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-018 In FETCH, IRWrite and PCUpdate SHALL be 1 only when mem_ready=1; in MEMWRITE, MemWrite SHALL stay asserted every wait cycle until mem_ready.
REQ-019 Any wait state with mem_ready=0 SHALL hold its state and all of its outputs unchanged, with no cycle limit.
REQ-020 ImmSrc SHALL be decoded combinationally from op: 0100011->01, 1100011->10, 1101111->11, all other ops->00.
REQ-021 halted SHALL be 1 exactly while the state is HALT; in HALT all strobes SHALL be 0.
REQ-022 Cycles per instruction with zero wait states SHALL be: lw 5; sw, R-type, I-type and jal 4; beq 3.

Reset
REQ-023 rst sampled high at a clock edge SHALL force the state to FETCH and halted to 0 from any state, including HALT and a mid-access wait.
REQ-024 While rst is high, PCUpdate, IRWrite, RegWrite, MemWrite and Branch SHALL be forced to 0, and the selects SHALL take their FETCH values.

Structure
REQ-025 The package riscv_ctrl_pkg SHALL hold the state enum, the opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL) and the select encodings.
REQ-026 There SHALL be exactly one sub-module, immsrc_dec, the combinational op->ImmSrc decoder; the FSM SHALL be a single next-state process plus an output decode.

Verification
REQ-027 Reset then op=0000011 with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, with RegWrite=1 in cycle 5 only and ImmSrc=00.
REQ-028 op=0100011 with mem_ready low for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, then FETCH; ImmSrc=01.
REQ-029 mem_ready=0 for 3 cycles in FETCH -> IRWrite=PCUpdate=0 and state FETCH held; on the 4th cycle with mem_ready=1, IRWrite=PCUpdate=1, then DECODE.
REQ-030 op=1100011 -> FETCH, DECODE, BEQ with Branch=1 and ALUOp=01, then FETCH (3 cycles); op=1101111 -> JAL with PCUpdate=1, then ALUWB with RegWrite=1.
REQ-031 op=1111111 with ILLEGAL_HALT=1 -> halted=1 and all strobes 0 for 10+ cycles, cleared by rst; with ILLEGAL_HALT=0 -> DECODE then FETCH and halted=0.
REQ-032 rst asserted in MEMWRITE -> MemWrite=0 in the same cycle, state FETCH on the next edge, then a normal fetch.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit:
// FSM state encoding, opcode values and datapath select encodings.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned ENC_W = 4;

  typedef enum logic [ENC_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  // ALU operand A select
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

  // ALU operand B select
  localparam logic [SEL_W-1:0] SRCB_RD2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  // Result select
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

  // ALU operation class
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format
  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

endpackage

// File: rtl/immsrc_dec.sv
// Immediate-format decoder: maps the opcode to the ImmSrc select.
// Ports: op_i (opcode), imm_src_o (immediate format select, combinational).
module immsrc_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op_i,
  output logic [SEL_W-1:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM (lw, sw, R, I, beq, jal) with optional
// memory handshake and an optional sticky halt on illegal opcodes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op, mem_ready       opcode, memory access done this cycle
//   PCUpdate..Branch    write strobes (gated by rst and mem_ready in FETCH)
//   AdrSrc, ALUSrcA/B, ResultSrc, ALUOp, ImmSrc   datapath selects
//   halted              high while in HALT
//   state_dbg           current state, debug only
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          ILLEGAL_HALT  = 1'b1,
  parameter int unsigned STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic               PCUpdate,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               Branch,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               halted,
  output logic [STATE_W-1:0] state_dbg
);

  state_e state_q, state_d;
  logic   mem_rdy_c;

  // Without the handshake every access completes in one cycle.
  assign mem_rdy_c = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy_c) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_rdy_c) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_rdy_c) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; reset overrides the current state with FETCH selects and no strobes.
  always_comb begin
    PCUpdate  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    Branch    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    ALUOp     = ALUOP_ADD;
    if (rst) begin
      ALUSrcB   = SRCB_FOUR;
      ResultSrc = RES_ALURES;
    end else begin
      case (state_q)
        S_FETCH: begin
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
          IRWrite   = mem_rdy_c;
          PCUpdate  = mem_rdy_c;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RD1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BEQ: begin
          ALUSrcA = SRCA_RD1;
          ALUOp   = ALUOP_SUB;
          Branch  = 1'b1;
        end
        S_JAL: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          PCUpdate = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted    = (state_q == S_HALT);
  assign state_dbg = STATE_W'(state_q);

  immsrc_dec u_immsrc_dec (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one default instance and one with
// ILLEGAL_HALT=0, MEM_HANDSHAKE=0 sharing the same inputs.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       mem_ready;

  logic       pcu, irw, rgw, mw, br, adr, hlt;
  logic [1:0] sa, sb, rs, ao, imm;
  logic [3:0] st;

  logic       pcu2, irw2, rgw2, mw2, br2, adr2, hlt2;
  logic [1:0] sa2, sb2, rs2, ao2, imm2;
  logic [3:0] st2;

  int total = 0;
  int bad   = 0;

  logic [20:0] obs;
  assign obs = {st, pcu, irw, rgw, mw, br, adr, sa, sb, rs, ao, imm, hlt};

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCUpdate(pcu), .IRWrite(irw), .RegWrite(rgw), .MemWrite(mw), .Branch(br),
    .AdrSrc(adr), .ALUSrcA(sa), .ALUSrcB(sb), .ResultSrc(rs), .ALUOp(ao),
    .ImmSrc(imm), .halted(hlt), .state_dbg(st)
  );

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_HALT(1'b0)) dut2 (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCUpdate(pcu2), .IRWrite(irw2), .RegWrite(rgw2), .MemWrite(mw2), .Branch(br2),
    .AdrSrc(adr2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ResultSrc(rs2), .ALUOp(ao2),
    .ImmSrc(imm2), .halted(hlt2), .state_dbg(st2)
  );

  // Advance to the middle of the next cycle
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full output check of the default instance. stb = {PCUpdate,IRWrite,RegWrite,MemWrite,Branch}
  task automatic ex(input string tag, input logic [3:0] s, input logic [4:0] stb,
                    input logic a_src, input logic [1:0] a, input logic [1:0] b,
                    input logic [1:0] r, input logic [1:0] o, input logic [1:0] i,
                    input logic h);
    logic [20:0] e;
    #1;
    e = {s, stb, a_src, a, b, r, o, i, h};
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    #1;
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial begin
    rst = 1'b1; op = 7'h00; mem_ready = 1'b1;
    @(negedge clk);
    // strobes forced low in reset even with mem_ready high
    ex("reset", S_FETCH, 5'b00000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0);

    // lw, no waits: 5 cycles
    rst = 1'b0; op = OP_LW;
    ex("lw_fetch",  S_FETCH,   5'b11000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0); cyc();
    ex("lw_decode", S_DECODE,  5'b00000, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0); cyc();
    ex("lw_memadr", S_MEMADR,  5'b00000, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 0); cyc();
    ex("lw_memrd",  S_MEMREAD, 5'b00000, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); cyc();
    ex("lw_memwb",  S_MEMWB,   5'b00100, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0); cyc();

    // sw with two wait cycles in MEMWRITE
    op = OP_SW;
    ex("sw_fetch",  S_FETCH,    5'b11000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 0); cyc();
    ex("sw_decode", S_DECODE,   5'b00000, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 0); cyc();
    ex("sw_memadr", S_MEMADR,   5'b00000, 0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 0); cyc();
    mem_ready = 1'b0;
    ex("sw_wr1",    S_MEMWRITE, 5'b00010, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0); cyc();
    ex("sw_wr2",    S_MEMWRITE, 5'b00010, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0); cyc();
    mem_ready = 1'b1;
    ex("sw_wr3",    S_MEMWRITE, 5'b00010, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0); cyc();

    // FETCH held 3 cycles, then beq
    op = OP_BEQ; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ex("fetch_wait", S_FETCH, 5'b00000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 0); cyc();
    end
    mem_ready = 1'b1;
    ex("fetch_go",   S_FETCH,  5'b11000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 0); cyc();
    ex("beq_decode", S_DECODE, 5'b00000, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 0); cyc();
    ex("beq_exec",   S_BEQ,    5'b00001, 0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 0); cyc();

    // jal
    op = OP_JAL;
    ex("jal_fetch",  S_FETCH,  5'b11000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b11, 0); cyc();
    ex("jal_decode", S_DECODE, 5'b00000, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 0); cyc();
    ex("jal_exec",   S_JAL,    5'b10000, 0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 0); cyc();
    ex("jal_wb",     S_ALUWB,  5'b00100, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0); cyc();

    // I-type
    op = OP_I; cyc(); cyc();
    ex("i_exec",     S_EXECI,  5'b00000, 0, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 0); cyc();
    ex("i_wb",       S_ALUWB,  5'b00100, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0); cyc();

    // R-type
    op = OP_R; cyc(); cyc();
    ex("r_exec",     S_EXECR,  5'b00000, 0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 0); cyc();
    cyc();

    // illegal opcode halts until reset
    op = 7'b1111111;
    chk("ill_fetch_state", 32'(st), 32'(S_FETCH)); cyc(); cyc();
    for (int k = 0; k < 11; k++) begin
      mem_ready = k[0];
      ex("halt_hold", S_HALT, 5'b00000, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1); cyc();
    end
    rst = 1'b1; mem_ready = 1'b1;
    ex("halt_in_rst", S_HALT,  5'b00000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1); cyc();
    ex("halt_cleared", S_FETCH, 5'b00000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0);

    // second instance: no handshake, illegal op skips back to FETCH
    rst = 1'b0; mem_ready = 1'b0;
    chk("nh_fetch_irw", 32'(irw2), 32'd1);
    chk("hs_fetch_irw", 32'(irw), 32'd0); cyc();
    chk("nh_decode", 32'(st2), 32'(S_DECODE));
    chk("hs_held",   32'(st),  32'(S_FETCH)); cyc();
    chk("nh_refetch", 32'(st2), 32'(S_FETCH));
    chk("nh_halted",  32'(hlt2), 32'd0);

    // reset during a MEMWRITE wait
    rst = 1'b1; cyc();
    rst = 1'b0; op = OP_SW; mem_ready = 1'b1; cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    ex("rw_wait",  S_MEMWRITE, 5'b00010, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    rst = 1'b1;
    ex("rw_rst",   S_MEMWRITE, 5'b00000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 0); cyc();
    rst = 1'b0; mem_ready = 1'b1;
    ex("rw_fetch", S_FETCH,    5'b11000, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 0); cyc();
    ex("rw_decode", S_DECODE,  5'b00000, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
